// File: rtl/adc_sample_packer.sv
// rtl/adc_sample_packer.sv - ADC sample capture FIFO packed into a header-framed UART byte stream
module adc_sample_packer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [11:0] I_adc_data,
    input  logic        I_adc_data_valid,
    input  logic        I_capture_start,
    input  logic [15:0] I_capture_len,
    output logic [7:0]  O_tx_data,
    output logic        O_tx_valid,
    input  logic        I_tx_ready,
    output logic        O_busy,
    output logic        O_done,
    output logic        O_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FILL_MAX = FIFO_DEPTH[AW:0];

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR0   = 3'd1;
    localparam logic [2:0] ST_HDR1   = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]    state;
    logic [11:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill;
    logic [15:0]   cap_len;
    logic [15:0]   cap_cnt;
    logic          byte_sel;   // 0: high nibble byte next, 1: low byte next
    logic          overflow;

    logic          start_ok;
    logic          capturing;
    logic          strobe_in;
    logic          fifo_empty;
    logic          fifo_full;
    logic          tx_fire;
    logic          fifo_rd;
    logic          fifo_wr;
    logic          drop;
    logic [11:0]   head;

    assign start_ok   = (state == ST_IDLE) && I_capture_start && (I_capture_len != 16'd0);
    // Sampling runs alongside header transmission, so every busy state captures.
    assign capturing  = (state == ST_HDR0) || (state == ST_HDR1) || (state == ST_STREAM);
    assign strobe_in  = capturing && I_adc_data_valid && (cap_cnt != cap_len);
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == FILL_MAX);
    assign head       = mem[rd_ptr];
    assign tx_fire    = O_tx_valid && I_tx_ready;
    // An entry leaves the FIFO only once its low byte has been accepted.
    assign fifo_rd    = (state == ST_STREAM) && tx_fire && byte_sel;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the sample.
    assign fifo_wr    = strobe_in && (!fifo_full || fifo_rd);
    assign drop       = strobe_in && !fifo_wr;

    assign O_busy     = capturing;
    assign O_done     = (state == ST_DONE);
    assign O_overflow = overflow;

    // Byte presented to the UART; holds steady under backpressure because the head only moves on pop.
    always_comb begin
        O_tx_valid = 1'b0;
        O_tx_data  = 8'h00;
        case (state)
            ST_HDR0: begin
                O_tx_valid = 1'b1;
                O_tx_data  = 8'hA5;
            end
            ST_HDR1: begin
                O_tx_valid = 1'b1;
                O_tx_data  = 8'h5A;
            end
            ST_STREAM: begin
                if (!fifo_empty) begin
                    O_tx_valid = 1'b1;
                    O_tx_data  = byte_sel ? head[7:0] : {4'h0, head[11:8]};
                end
            end
            default: begin
                O_tx_valid = 1'b0;
                O_tx_data  = 8'h00;
            end
        endcase
    end

    // Sample storage; contents need no reset since the pointers define validity.
    always_ff @(posedge I_clk) begin
        if (!I_rst && fifo_wr) begin
            mem[wr_ptr] <= I_adc_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Capture sequencing: header, streamed samples, done pulse, plus sample counting.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state    <= ST_IDLE;
            cap_len  <= 16'd0;
            cap_cnt  <= 16'd0;
            byte_sel <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        cap_len  <= I_capture_len;
                        cap_cnt  <= 16'd0;
                        byte_sel <= 1'b0;
                        overflow <= 1'b0;
                        state    <= ST_HDR0;
                    end
                end
                ST_HDR0: begin
                    if (tx_fire) begin
                        state <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (tx_fire) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (tx_fire) begin
                        byte_sel <= ~byte_sel;
                    end
                    // byte_sel is back at 0 whenever the FIFO is empty, so nothing is half-sent here.
                    if ((cap_cnt == cap_len) && fifo_empty) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (strobe_in) begin
                cap_cnt <= cap_cnt + 16'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_packer.sv
// tb/tb_adc_sample_packer.sv - self-checking bench for adc_sample_packer against a byte-queue model
module tb_adc_sample_packer;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic [11:0] adc;
    logic        strobe;
    logic        start;
    logic [15:0] len_in;
    logic [7:0]  O_tx_data;
    logic        O_tx_valid;
    logic        ready;
    logic        O_busy;
    logic        O_done;
    logic        O_overflow;

    adc_sample_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .I_clk            (clk),
        .I_rst            (rst),
        .I_adc_data       (adc),
        .I_adc_data_valid (strobe),
        .I_capture_start  (start),
        .I_capture_len    (len_in),
        .O_tx_data        (O_tx_data),
        .O_tx_valid       (O_tx_valid),
        .I_tx_ready       (ready),
        .O_busy           (O_busy),
        .O_done           (O_done),
        .O_overflow       (O_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: expected outgoing bytes in order, header bytes first.
    logic [7:0] q[$];
    logic [7:0] log_q[$];
    int         m_phase;   // 0 idle, 1 busy, 2 done cycle
    int         m_hdr;
    int         m_len;
    int         m_cnt;
    int         m_pushed;
    bit         m_ovf;
    int         tx_count;
    int         done_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_phase  = 0;
        m_hdr    = 0;
        m_len    = 0;
        m_cnt    = 0;
        m_pushed = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic step();
        logic       ev;
        logic [7:0] ed;
        int         nsamp;
        int         occ;
        bit         hs;
        bit         pop_low;
        bit         go_done;
        @(negedge clk);
        ev = (m_phase == 1) && (q.size() != 0);
        ed = ev ? q[0] : 8'h00;
        chk("tx_valid", 32'(O_tx_valid), 32'(ev));
        chk("tx_data", 32'(O_tx_data), 32'(ed));
        chk("busy", 32'(O_busy), 32'(m_phase == 1));
        chk("done", 32'(O_done), 32'(m_phase == 2));
        chk("overflow", 32'(O_overflow), 32'(m_ovf));
        if (O_tx_valid && ready) begin
            tx_count++;
            log_q.push_back(O_tx_data);
        end
        if (O_done) done_count++;
        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    if (start && len_in != 16'd0) begin
                        m_phase  = 1;
                        m_len    = int'(len_in);
                        m_cnt    = 0;
                        m_pushed = 0;
                        m_ovf    = 1'b0;
                        q.delete();
                        q.push_back(8'hA5);
                        q.push_back(8'h5A);
                        m_hdr = 2;
                    end
                end
                1: begin
                    nsamp   = q.size() - m_hdr;
                    occ     = (nsamp + 1) / 2;
                    hs      = ev && ready;
                    pop_low = hs && (m_hdr == 0) && (nsamp % 2 == 1);
                    go_done = (m_hdr == 0) && (q.size() == 0) && (m_cnt == m_len);
                    if (hs) begin
                        void'(q.pop_front());
                        if (m_hdr > 0) m_hdr--;
                    end
                    if (strobe && m_cnt < m_len) begin
                        m_cnt++;
                        if (occ < DEPTH || pop_low) begin
                            q.push_back({4'h0, adc[11:8]});
                            q.push_back(adc[7:0]);
                            m_pushed++;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    if (go_done) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic begin_capture(input logic [15:0] len);
        tx_count   = 0;
        done_count = 0;
        log_q.delete();
        start  = 1'b1;
        len_in = len;
        step();
        start = 1'b0;
    endtask

    task automatic run_capture(input int budget, input bit rnd_ready, input bit rnd_strobe);
        int i;
        i = 0;
        while (m_phase != 0 && i < budget) begin
            ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            strobe = rnd_strobe ? ($urandom_range(0, 2) == 0) : 1'b0;
            adc    = 12'($urandom_range(0, 4095));
            step();
            i++;
        end
        strobe = 1'b0;
        ready  = 1'b1;
        chk("run_in_budget", 32'(i < budget), 32'd1);
    endtask

    initial begin
        logic [7:0]  exp30 [8];
        logic [11:0] smp30 [3];
        exp30 = '{8'hA5, 8'h5A, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h00, 8'hFF};
        smp30 = '{12'hABC, 12'h123, 12'h0FF};

        rst = 1'b1; adc = '0; strobe = 1'b0; start = 1'b0; len_in = '0; ready = 1'b0;
        model_reset();
        tx_count = 0; done_count = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("reset_tx_data", 32'(O_tx_data), 32'h00);
        chk("reset_busy", 32'(O_busy), 32'd0);

        // Three known samples with the UART always ready.
        ready = 1'b1;
        begin_capture(16'd3);
        for (int i = 0; i < 3; i++) begin
            strobe = 1'b1;
            adc    = smp30[i];
            step();
        end
        strobe = 1'b0;
        run_capture(200, 1'b0, 1'b0);
        chk("t30_bytes", 32'(tx_count), 32'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            chk("t30_byte", 32'(log_q[i]), 32'(exp30[i]));
        end
        chk("t30_done_pulses", 32'(done_count), 32'd1);
        chk("t30_overflow", 32'(O_overflow), 32'd0);

        // Twenty samples while the UART is stalled: sixteen kept, overflow flagged.
        ready = 1'b0;
        begin_capture(16'd20);
        for (int i = 0; i < 20; i++) begin
            strobe = 1'b1;
            adc    = 12'($urandom_range(0, 4095));
            step();
        end
        strobe = 1'b0;
        step();
        chk("t31_overflow", 32'(O_overflow), 32'd1);
        chk("t31_no_bytes", 32'(tx_count), 32'd0);
        run_capture(500, 1'b0, 1'b0);
        chk("t31_bytes", 32'(tx_count), 32'd34);
        chk("t31_done_pulses", 32'(done_count), 32'd1);
        chk("t31_overflow_held", 32'(O_overflow), 32'd1);

        // Random backpressure and random strobe spacing.
        begin_capture(16'd100);
        run_capture(5000, 1'b1, 1'b1);
        chk("t32_bytes", 32'(tx_count), 32'(2 + 2 * m_pushed));
        chk("t32_done_pulses", 32'(done_count), 32'd1);

        // Zero-length start is ignored.
        start = 1'b1; len_in = 16'd0;
        step();
        start = 1'b0;
        step();
        chk("t33_len0_busy", 32'(O_busy), 32'd0);
        chk("t33_len0_valid", 32'(O_tx_valid), 32'd0);

        // Restart while busy is ignored; strobes beyond len are ignored.
        ready = 1'b0;
        begin_capture(16'd2);
        start = 1'b1; len_in = 16'd5; strobe = 1'b1; adc = 12'h321;
        step();
        start = 1'b0; adc = 12'h654;
        step();
        adc = 12'h987;
        step();
        step();
        strobe = 1'b0;
        run_capture(200, 1'b0, 1'b0);
        chk("t33_bytes", 32'(tx_count), 32'd6);
        chk("t33_last_byte", 32'(log_q.size() == 6 ? log_q[5] : 8'hXX), 32'h54);

        // Strobe on the acceptance cycle is not captured.
        ready = 1'b1;
        strobe = 1'b1; adc = 12'hFED;
        begin_capture(16'd1);
        adc = 12'h7C1;
        step();
        adc = 12'h111;
        step();
        strobe = 1'b0;
        run_capture(200, 1'b0, 1'b0);
        chk("t35_bytes", 32'(tx_count), 32'd4);
        chk("t35_hi", 32'(log_q.size() == 4 ? log_q[2] : 8'hXX), 32'h07);
        chk("t35_lo", 32'(log_q.size() == 4 ? log_q[3] : 8'hXX), 32'hC1);

        // Reset in the middle of streaming aborts the capture and clears flags.
        ready = 1'b0;
        begin_capture(16'd20);
        for (int i = 0; i < 20; i++) begin
            strobe = 1'b1;
            adc    = 12'($urandom_range(0, 4095));
            step();
        end
        strobe = 1'b0;
        ready  = 1'b1;
        repeat (4) step();
        chk("t34_pre_overflow", 32'(O_overflow), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t34_valid", 32'(O_tx_valid), 32'd0);
        chk("t34_busy", 32'(O_busy), 32'd0);
        chk("t34_overflow", 32'(O_overflow), 32'd0);
        chk("t34_data", 32'(O_tx_data), 32'h00);
        tx_count = 0;
        repeat (3) step();
        chk("t34_quiet", 32'(tx_count), 32'd0);
        begin_capture(16'd1);
        strobe = 1'b1; adc = 12'h5E3;
        step();
        strobe = 1'b0;
        run_capture(200, 1'b0, 1'b0);
        chk("t34_bytes", 32'(tx_count), 32'd4);
        chk("t34_hdr0", 32'(log_q.size() > 0 ? log_q[0] : 8'hXX), 32'hA5);
        chk("t34_hdr1", 32'(log_q.size() > 1 ? log_q[1] : 8'hXX), 32'h5A);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/adc_sample_packer.md
ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 16, sample buffer depth in 12-bit entries (power of 2, >=4).
REQ-002 SHALL provide port I_clk, input, 1, system clock (200 MHz).
REQ-003 SHALL provide port I_rst, input, 1, synchronous active-high reset.
REQ-004 SHALL provide port I_adc_data, input, 12, parallel ADC sample word.
REQ-005 SHALL provide port I_adc_data_valid, input, 1, single-cycle strobe from the ADC clock generator; sample I_adc_data on this cycle.
REQ-006 SHALL provide port I_capture_start, input, 1, single-cycle pulse starting a capture.
REQ-007 SHALL provide port I_capture_len, input, 16, number of samples to capture; latched on accepted start.
REQ-008 SHALL provide port O_tx_data, output, 8, byte to the UART transmitter.
REQ-009 SHALL provide port O_tx_valid, output, 1, O_tx_data holds a valid byte.
REQ-010 SHALL provide port I_tx_ready, input, 1, UART accepts byte when high with O_tx_valid.
REQ-011 SHALL provide port O_busy, output, 1, high from accepted start until capture done.
REQ-012 SHALL provide port O_done, output, 1, one-cycle pulse at capture end.
REQ-013 SHALL provide port O_overflow, output, 1, sticky: a sample was dropped in the current/last capture.

Function
REQ-014 SHALL implement states IDLE, HDR0, HDR1, STREAM, DONE.
REQ-015 IDLE: I_capture_start with I_capture_len != 0 SHALL latch len, clear sample counters, clear O_overflow, assert O_busy next cycle, go HDR0.
REQ-016 I_capture_start with I_capture_len == 0, or any start while O_busy, SHALL be ignored (no state/flag change).
REQ-017 Capture SHALL begin the cycle after the start is accepted: each I_adc_data_valid while captured count < len SHALL write I_adc_data into the FIFO and increment captured count; strobes after count == len SHALL be ignored.
REQ-018 Strobe with FIFO full SHALL drop the sample, set O_overflow, and still increment captured count.
REQ-019 HDR0 SHALL present 8'hA5, HDR1 8'h5A; each advances on O_tx_valid && I_tx_ready.
REQ-020 STREAM: per FIFO entry, SHALL send byte {4'h0, d[11:8]} then byte d[7:0]; entry popped after the low byte is accepted.
REQ-021 STREAM SHALL assert O_tx_valid only when a byte is available; O_tx_valid SHALL not deassert and O_tx_data SHALL not change while O_tx_valid && !I_tx_ready.
REQ-022 STREAM SHALL go to DONE when captured count == len, FIFO empty, and no byte pending.
REQ-023 DONE SHALL pulse O_done for exactly one cycle, deassert O_busy that same cycle, and return to IDLE; O_overflow SHALL hold its value until next accepted start or reset.
REQ-024 FIFO write and read in the same cycle SHALL both proceed, including when full (read frees the slot) and when empty (no read occurs); occupancy SHALL never exceed FIFO_DEPTH.
REQ-025 Capture runs concurrently with HDR0/HDR1; samples arriving during header transmission SHALL be buffered, not dropped unless the FIFO is full.
REQ-026 Capture counters SHALL be 16 bit; len up to 65535 SHALL be supported without wrap.
REQ-027 Write latency: sample in FIFO on the clock edge where I_adc_data_valid is high; high byte earliest on O_tx_data the cycle after header byte 2 accepted.

Reset
REQ-028 I_rst high at a clock edge SHALL force IDLE, empty FIFO, clear counters, O_tx_valid=0, O_tx_data=8'h00, O_busy=0, O_done=0, O_overflow=0, aborting any capture mid-stream without emitting further bytes.
REQ-029 Reset SHALL take precedence over all other inputs on the same cycle.

Verification
REQ-030 len=3, I_tx_ready=1, samples 12'hABC,12'h123,12'h0FF -> bytes A5,5A,0A,BC,01,23,00,FF; O_done one pulse; O_overflow=0.
REQ-031 len=20, I_tx_ready=0 throughout strobes, FIFO_DEPTH=16 -> 16 stored, O_overflow=1; on ready=1, 2+32 bytes sent then O_done.
REQ-032 Random I_tx_ready backpressure, len=100 -> O_tx_data stable whenever valid && !ready; byte sequence equals model.
REQ-033 Start with len=0, and second start while busy -> no header, no state change, O_busy unaffected.
REQ-034 I_rst asserted mid-STREAM -> next cycle O_tx_valid=0, O_busy=0, O_overflow=0; new start with len=1 yields A5,5A, 2 bytes.
REQ-035 Strobes after len reached, and strobe on start-acceptance cycle -> ignored; byte count exactly 2+2*len.
